// File: rtl/ofdm_ifft_manager_if.sv
// Symbol-load, result-stream and status signals of the OFDM IFFT manager.
// The master side feeds samples and drains results; the slave side is the block itself.
interface ofdm_ifft_manager_if;
  logic        start;
  logic [31:0] data_in;
  logic        data_valid;
  logic        s_axis_data_tready;
  logic        s_axis_config_tready;
  logic        m_axis_data_tready;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [15:0] m_axis_real_unsigned;
  logic        busy;
  logic        done;

  modport master (
    output start, data_in, data_valid, m_axis_data_tready,
    input  s_axis_data_tready, s_axis_config_tready, data_out, data_out_valid,
    input  m_axis_real_unsigned, busy, done
  );

  modport slave (
    input  start, data_in, data_valid, m_axis_data_tready,
    output s_axis_data_tready, s_axis_config_tready, data_out, data_out_valid,
    output m_axis_real_unsigned, busy, done
  );
endinterface

// File: rtl/ofdm_ifft_manager.sv
// Buffers one OFDM symbol, computes its inverse DFT with one complex MAC per cycle,
// and streams the scaled time-domain samples out with backpressure.
module ofdm_ifft_manager #(
  parameter int POINTS = 16,
  parameter int LOG2P  = 4
) (
  input logic               aclk,
  input logic               aresetn,
  ofdm_ifft_manager_if.slave bus
);

  localparam int CW    = LOG2P + 1;
  localparam int ACC_W = 40;
  localparam logic [LOG2P-1:0]       IDX_LAST = LOG2P'(POINTS - 1);
  localparam logic [CW-1:0]          CNT_FULL = CW'(POINTS);
  localparam logic [CW-1:0]          CNT_LAST = CW'(POINTS - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = 40'sd1 <<< (14 + LOG2P);

  // Quarter-wave cosine for a 64-point circle, Q1.15 with +1 mapped to 32767.
  localparam logic signed [15:0] QTAB [17] = '{
    16'sd32767, 16'sd32609, 16'sd32137, 16'sd31356, 16'sd30273, 16'sd28898,
    16'sd27245, 16'sd25329, 16'sd23170, 16'sd20787, 16'sd18204, 16'sd15446,
    16'sd12539, 16'sd9512,  16'sd6393,  16'sd3212,  16'sd0
  };

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT} state_e;

  function automatic logic signed [15:0] cos64(input logic [5:0] m);
    logic [4:0] r;
    logic [4:0] rr;
    r  = {1'b0, m[3:0]};
    rr = 5'd16 - r;
    case (m[5:4])
      2'd0:    cos64 = QTAB[r];
      2'd1:    cos64 = -QTAB[rr];
      2'd2:    cos64 = -QTAB[r];
      default: cos64 = QTAB[rr];
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > 40'sd32767)       sat16 = 16'sh7fff;
    else if (v < -40'sd32768) sat16 = 16'sh8000;
    else                      sat16 = v[15:0];
  endfunction

  // Twiddle ROM: entry i holds W = cos(2*pi*i/POINTS) + j*sin(2*pi*i/POINTS).
  logic signed [15:0] rom_cos [POINTS];
  logic signed [15:0] rom_sin [POINTS];
  for (genvar g = 0; g < POINTS; g++) begin : g_rom
    localparam logic [5:0] M = 6'(g * (64 / POINTS));
    assign rom_cos[g] = cos64(M);
    assign rom_sin[g] = cos64(M + 6'd48);
  end

  state_e                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [LOG2P-1:0]         k_q, k_d, n_q, n_d, out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [31:0]              data_out_q, data_out_d;
  logic                     valid_q, valid_d, done_q, done_d;

  logic [31:0]              sym_mem [POINTS];
  logic [31:0]              res_mem [POINTS];
  logic                     sym_we, res_we;
  logic [LOG2P-1:0]         sym_waddr, res_waddr;
  logic [31:0]              res_wdata;

  logic [LOG2P-1:0]         tw_idx, out_nxt;
  logic [31:0]              x_word;
  logic signed [15:0]       xr, xi, wc, ws;
  logic signed [31:0]       p_rc, p_is, p_rs, p_ic;
  logic signed [ACC_W-1:0]  mac_re, mac_im, rnd_re, rnd_im;

  // Entries beyond the loaded count read as zero, which covers an aborted load.
  always_comb begin
    tw_idx = k_q * n_q;
    x_word = ({1'b0, k_q} < count_q) ? sym_mem[k_q] : 32'h0;
    xr     = x_word[15:0];
    xi     = x_word[31:16];
    wc     = rom_cos[tw_idx];
    ws     = rom_sin[tw_idx];
    p_rc   = xr * wc;
    p_is   = xi * ws;
    p_rs   = xr * ws;
    p_ic   = xi * wc;
    mac_re = acc_re_q + ACC_W'(p_rc) - ACC_W'(p_is);
    mac_im = acc_im_q + ACC_W'(p_rs) + ACC_W'(p_ic);
    rnd_re = (mac_re + RND_HALF) >>> (15 + LOG2P);
    rnd_im = (mac_im + RND_HALF) >>> (15 + LOG2P);
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    k_d        = k_q;
    n_d        = n_q;
    out_idx_d  = out_idx_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    sym_we     = 1'b0;
    sym_waddr  = count_q[LOG2P-1:0];
    res_we     = 1'b0;
    res_waddr  = n_q;
    res_wdata  = {sat16(rnd_im), sat16(rnd_re)};
    out_nxt    = out_idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        k_d       = '0;
        n_d       = '0;
        out_idx_d = '0;
        acc_re_d  = '0;
        acc_im_d  = '0;
        count_d   = '0;
        if (bus.start && bus.data_valid) begin
          sym_we    = 1'b1;
          sym_waddr = '0;
          count_d   = CW'(1);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!bus.start) begin
          state_d = S_COMPUTE;
        end else if (bus.data_valid && count_q < CNT_FULL) begin
          sym_we  = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CNT_LAST) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (k_q == IDX_LAST) begin
          res_we   = 1'b1;
          acc_re_d = '0;
          acc_im_d = '0;
          k_d      = '0;
          if (n_q == IDX_LAST) begin
            state_d    = S_OUTPUT;
            done_d     = 1'b1;
            valid_d    = 1'b1;
            out_idx_d  = '0;
            data_out_d = res_mem[0];
          end else begin
            n_d = n_q + 1'b1;
          end
        end else begin
          acc_re_d = mac_re;
          acc_im_d = mac_im;
          k_d      = k_q + 1'b1;
        end
      end
      default: begin
        if (valid_q && bus.m_axis_data_tready) begin
          if (out_idx_q == IDX_LAST) begin
            valid_d = 1'b0;
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            out_idx_d  = out_nxt;
            data_out_d = res_mem[out_nxt];
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      k_q        <= '0;
      n_q        <= '0;
      out_idx_q  <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      k_q        <= k_d;
      n_q        <= n_d;
      out_idx_q  <= out_idx_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // NOTE: buffers are not reset; their contents are always written before being read.
  always_ff @(posedge aclk) begin
    if (sym_we) sym_mem[sym_waddr] <= bus.data_in;
    if (res_we) res_mem[res_waddr] <= res_wdata;
  end

  assign bus.busy                 = (state_q != S_IDLE);
  assign bus.s_axis_config_tready = (state_q == S_IDLE);
  assign bus.s_axis_data_tready   = (state_q == S_IDLE) ||
                                    ((state_q == S_LOAD) && (count_q < CNT_FULL));
  assign bus.data_out             = data_out_q;
  assign bus.data_out_valid       = valid_q;
  assign bus.done                 = done_q;
  assign bus.m_axis_real_unsigned = {~data_out_q[15], data_out_q[14:0]};

endmodule

// File: tb/tb_ofdm_ifft_manager.sv
// Self-checking bench for ofdm_ifft_manager: table of symbols, double-precision IDFT
// model feeding a scoreboard queue, plus reset and backpressure sequences.
module tb_ofdm_ifft_manager;
  localparam int POINTS = 16;
  localparam int LOG2P  = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ofdm_ifft_manager_if bus();

  ofdm_ifft_manager #(.POINTS(POINTS), .LOG2P(LOG2P)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    string                    name;
    int                       n_load;
    logic [POINTS-1:0][31:0]  x;
    bit                       bp;
    bit                       chk_first;
    logic [31:0]              exp_first;
  } vec_t;

  typedef struct {
    int re;
    int im;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic int model_y(input logic [POINTS-1:0][31:0] x, input int nld,
                                 input int n, input bit want_im);
    real     re, im, ang, e;
    shortint sr, si;
    int      r;
    re = 0.0;
    im = 0.0;
    for (int k = 0; k < nld; k++) begin
      sr  = x[k][15:0];
      si  = x[k][31:16];
      ang = 2.0 * 3.14159265358979 * real'(k * n) / real'(POINTS);
      re  = re + real'(sr) * $cos(ang) - real'(si) * $sin(ang);
      im  = im + real'(sr) * $sin(ang) + real'(si) * $cos(ang);
    end
    e = (want_im ? im : re) / real'(POINTS);
    r = $rtoi($floor(e + 0.5));
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic bit near(input logic [15:0] a, input int e);
    shortint s;
    int      d;
    s = a;
    d = int'(s) - e;
    return (d >= -1) && (d <= 1);
  endfunction

  task automatic load_samples(input vec_t cur);
    for (int k = 0; k < cur.n_load; k++) begin
      bus.start      = 1'b1;
      bus.data_valid = 1'b1;
      bus.data_in    = cur.x[k];
      @(posedge aclk); #1;
    end
    if (cur.n_load == POINTS) begin
      check(!bus.s_axis_data_tready && bus.busy && !bus.s_axis_config_tready,
            {cur.name, "_full_load_flags"},
            32'({bus.s_axis_data_tready, bus.busy, bus.s_axis_config_tready}), 32'b010);
      // One more sample with start high: must be ignored outside IDLE/LOAD.
      bus.data_in = 32'h7fff_7fff;
      @(posedge aclk); #1;
    end
    bus.start      = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
  endtask

  task automatic run_vector(input int v);
    vec_t        cur;
    exp_t        e;
    int          cyc, beats;
    bit          stall;
    logic [31:0] prev, last, req;
    cur = vecs[v];
    check(bus.s_axis_config_tready === 1'b1, {cur.name, "_idle_config_tready"},
          32'(bus.s_axis_config_tready), 32'h1);
    for (int n = 0; n < POINTS; n++)
      sb.push_back('{re: model_y(cur.x, cur.n_load, n, 1'b0), im: model_y(cur.x, cur.n_load, n, 1'b1)});
    load_samples(cur);

    cyc = 0;
    while (!bus.done && cyc < 400) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check(bus.done === 1'b1 && cyc <= POINTS * POINTS + 2 * POINTS, {cur.name, "_done_latency"},
          32'(cyc), 32'(POINTS * POINTS + 2 * POINTS));
    if (bus.done !== 1'b1) begin
      sb.delete();
      return;
    end
    check(bus.data_out_valid === 1'b1, {cur.name, "_valid_with_done"}, 32'(bus.data_out_valid), 32'h1);
    if (cur.chk_first) begin
      check(bus.data_out === cur.exp_first, {cur.name, "_first_exact"}, bus.data_out, cur.exp_first);
      check(bus.m_axis_real_unsigned === (cur.exp_first[15:0] ^ 16'h8000), {cur.name, "_first_unsigned"},
            32'(bus.m_axis_real_unsigned), 32'(cur.exp_first[15:0] ^ 16'h8000));
    end

    beats = 0;
    cyc   = 0;
    stall = 1'b0;
    prev  = '0;
    last  = '0;
    while (beats < POINTS && cyc < 300) begin
      bus.m_axis_data_tready = cur.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall)
        check(bus.data_out_valid === 1'b1 && bus.data_out === prev, {cur.name, "_stall_hold"},
              bus.data_out, prev);
      if (bus.data_out_valid && bus.m_axis_data_tready) begin
        e   = sb.pop_front();
        req = {e.im[15:0], e.re[15:0]};
        check(near(bus.data_out[15:0], e.re) && near(bus.data_out[31:16], e.im),
              $sformatf("%s_y%0d", cur.name, beats), bus.data_out, req);
        check(near(bus.m_axis_real_unsigned ^ 16'h8000, e.re),
              $sformatf("%s_y%0d_unsigned", cur.name, beats),
              32'(bus.m_axis_real_unsigned), 32'(e.re[15:0] ^ 16'h8000));
        last = bus.data_out;
        beats++;
      end
      stall = bus.data_out_valid && !bus.m_axis_data_tready;
      prev  = bus.data_out;
      @(posedge aclk); #1;
      cyc++;
      if (cyc == 1) check(bus.done === 1'b0, {cur.name, "_done_one_cycle"}, 32'(bus.done), 32'h0);
    end
    bus.m_axis_data_tready = 1'b1;
    check(beats == POINTS, {cur.name, "_beat_count"}, 32'(beats), 32'(POINTS));
    if (!cur.bp) check(cyc == POINTS, {cur.name, "_back_to_back"}, 32'(cyc), 32'(POINTS));
    check(!bus.data_out_valid && !bus.busy && bus.s_axis_config_tready, {cur.name, "_return_idle"},
          32'({bus.data_out_valid, bus.busy, bus.s_axis_config_tready}), 32'b001);
    check(bus.data_out === last, {cur.name, "_data_out_hold"}, bus.data_out, last);
  endtask

  task automatic check_reset_values(input string tag);
    check(bus.busy === 1'b0, {tag, "_busy"}, 32'(bus.busy), 32'h0);
    check(bus.done === 1'b0, {tag, "_done"}, 32'(bus.done), 32'h0);
    check(bus.data_out_valid === 1'b0, {tag, "_valid"}, 32'(bus.data_out_valid), 32'h0);
    check(bus.s_axis_config_tready === 1'b1, {tag, "_config_tready"}, 32'(bus.s_axis_config_tready), 32'h1);
    check(bus.s_axis_data_tready === 1'b1, {tag, "_data_tready"}, 32'(bus.s_axis_data_tready), 32'h1);
    check(bus.data_out === 32'h0, {tag, "_data_out"}, bus.data_out, 32'h0);
    check(bus.m_axis_real_unsigned === 16'h8000, {tag, "_real_unsigned"},
          32'(bus.m_axis_real_unsigned), 32'h8000);
  endtask

  logic [31:0] qam_words [POINTS] = '{
    32'h0000_0000, 32'h8020_d5cd, 32'h8020_8020, 32'h2a33_7fe0,
    32'hd5cd_2a33, 32'h7fe0_8020, 32'h2a33_d5cd, 32'h8020_7fe0,
    32'h7fe0_7fe0, 32'hd5cd_d5cd, 32'h2a33_2a33, 32'h8020_2a33,
    32'h7fe0_d5cd, 32'hd5cd_8020, 32'h2a33_8020, 32'h7fe0_2a33
  };

  initial begin
    logic [POINTS-1:0][31:0] qam;
    vec_t                    abort_vec;

    bus.start              = 1'b0;
    bus.data_valid         = 1'b0;
    bus.data_in            = '0;
    bus.m_axis_data_tready = 1'b1;
    for (int k = 0; k < POINTS; k++) qam[k] = qam_words[k];

    vecs[0] = '{name: "impulse",  n_load: 16, x: '0,  bp: 1'b0, chk_first: 1'b1, exp_first: 32'h0000_0400};
    vecs[1] = '{name: "tone",     n_load: 16, x: '0,  bp: 1'b0, chk_first: 1'b1, exp_first: 32'h0000_0400};
    vecs[2] = '{name: "qam",      n_load: 16, x: qam, bp: 1'b0, chk_first: 1'b0, exp_first: 32'h0};
    vecs[3] = '{name: "qam_bp",   n_load: 16, x: qam, bp: 1'b1, chk_first: 1'b0, exp_first: 32'h0};
    vecs[4] = '{name: "short",    n_load: 8,  x: qam, bp: 1'b1, chk_first: 1'b0, exp_first: 32'h0};
    vecs[5] = '{name: "neg_imp",  n_load: 16, x: '0,  bp: 1'b1, chk_first: 1'b1, exp_first: 32'hf800_f800};
    vecs[0].x[0] = 32'h0000_4000;
    vecs[1].x[1] = 32'h0000_4000;
    vecs[5].x[0] = 32'h8000_8000;

    aresetn = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    check_reset_values("reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int v = 0; v < 6; v++) run_vector(v);

    // Reset asserted in the middle of COMPUTE takes effect immediately.
    abort_vec = vecs[2];
    load_samples(abort_vec);
    repeat (20) @(posedge aclk);
    #1;
    check(bus.busy === 1'b1, "mid_compute_busy", 32'(bus.busy), 32'h1);
    aresetn = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    run_vector(0);
    check(sb.size() == 0, "scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
